// File: rtl/exe_mdu_seq_pkg.sv
// Shared defines for the RV64M multiply/divide sequencer: op codes, FSM states, widths, helpers.
package exe_mdu_seq_pkg;

    localparam int unsigned MDU_XLEN  = 64;
    localparam int unsigned MDU_N64   = 64;
    localparam int unsigned MDU_N32   = 32;
    localparam int unsigned MDU_CNT_W = 7;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } mdu_op_e;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_CALC  = 4'b0010,
        ST_FIXUP = 4'b0100,
        ST_DONE  = 4'b1000
    } mdu_state_e;

    // 32-bit word ops run half the iterations and sign-extend their result
    function automatic logic is_w_op(input mdu_op_e op);
        return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    // Ops that return the quotient
    function automatic logic is_quo_op(input mdu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW};
    endfunction

    // Ops that return the remainder
    function automatic logic is_rem_op(input mdu_op_e op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic [MDU_XLEN-1:0] sext32(input logic [31:0] v);
        return {{(MDU_XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/exe_mdu_seq_if.sv
// Decode-to-MDU issue handshake and MDU-to-writeback result handshake.
interface exe_mdu_seq_if
    import exe_mdu_seq_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN
) ();

    logic            in_valid;
    logic            in_ready;
    mdu_op_e         op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    // Pipeline side: issues ops, consumes results
    modport master (
        output in_valid, op, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    // MDU side
    modport slave (
        input  in_valid, op, src1, src2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/mdu_iter_dp.sv
// One-bit-per-cycle datapath shared by the shift-add multiplier and restoring divider.
// Multiply: {hi,lo} is the 128-bit product register, lo starts as the multiplier, opa is the multiplicand.
// Divide:   hi is the partial remainder, lo shifts the dividend out and the quotient in, opa is the divisor.
module mdu_iter_dp #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            mode_div,
    input  logic [XLEN-1:0] opa_init,
    input  logic [XLEN-1:0] lo_init,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic [XLEN-1:0] opa_q;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_sh;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;

    // Per-iteration add (multiply) and trial subtract (divide)
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opa_q} : '0);
        div_sh   = {hi, lo[XLEN-1]};
        div_ge   = div_sh >= {1'b0, opa_q};
        div_diff = div_sh[XLEN-1:0] - opa_q;
    end

    // Operand load and one shift step per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (load) begin
            opa_q <= opa_init;
            hi    <= '0;
            lo    <= lo_init;
        end else if (step) begin
            if (mode_div) begin
                hi <= div_ge ? div_diff : div_sh[XLEN-1:0];
                lo <= {lo[XLEN-2:0], div_ge};
            end else begin
                hi <= mul_sum[XLEN:1];
                lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/exe_mdu_seq.sv
// Execute-stage RV64M sequencer: handshake, operand prep, special cases, iteration control, fix-up.
module exe_mdu_seq
    import exe_mdu_seq_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN  // only 64 is supported
) (
    input logic          clk,
    input logic          rst,
    exe_mdu_seq_if.slave bus
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e           state_q;
    logic [MDU_CNT_W-1:0] cnt_q;
    mdu_op_e              op_q;
    logic                 neg_q;
    logic [XLEN-1:0]      result_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic                 in_ready_q;

    logic            is_w, signed_a, signed_b, s1, s2, div_c, rem_c;
    logic            neg_c, dz, ovf, special, accept;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, dividend_w, special_val;
    logic [XLEN-1:0] dp_opa_init, dp_lo_init, dp_hi, dp_lo;
    logic [XLEN-1:0] quo, rem, fix_val;
    logic [2*XLEN-1:0] prod;

    // Operand prep, sign capture and special-case detection for the op on the input port
    always_comb begin
        is_w     = is_w_op(bus.op);
        rem_c    = is_rem_op(bus.op);
        div_c    = is_quo_op(bus.op) | rem_c;
        signed_a = bus.op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        signed_b = bus.op inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        if (is_w) begin
            a_ext = signed_a ? sext32(bus.src1[31:0]) : {{(XLEN-32){1'b0}}, bus.src1[31:0]};
            b_ext = signed_b ? sext32(bus.src2[31:0]) : {{(XLEN-32){1'b0}}, bus.src2[31:0]};
        end else begin
            a_ext = bus.src1;
            b_ext = bus.src2;
        end
        s1    = signed_a & a_ext[XLEN-1];
        s2    = signed_b & b_ext[XLEN-1];
        mag_a = s1 ? -a_ext : a_ext;
        mag_b = s2 ? -b_ext : b_ext;
        case (bus.op)
            OP_MULH, OP_DIV, OP_DIVW: neg_c = s1 ^ s2;
            OP_MULHSU, OP_REM, OP_REMW: neg_c = s1;
            default: neg_c = 1'b0;
        endcase
        dividend_w = is_w ? sext32(bus.src1[31:0]) : bus.src1;
        dz  = div_c && (b_ext == '0);
        ovf = div_c && signed_b && (b_ext == '1)
              && (is_w ? (bus.src1[31:0] == 32'h8000_0000) : (bus.src1 == MIN_NEG));
        special = dz | ovf;
        if (dz) begin
            special_val = rem_c ? dividend_w : '1;
        end else begin
            special_val = rem_c ? '0 : dividend_w;
        end
        // W divides pre-shift the 32-bit dividend to the top so 32 steps suffice
        dp_opa_init = div_c ? mag_b : mag_a;
        dp_lo_init  = div_c ? (is_w ? {mag_a[31:0], 32'h0} : mag_a) : mag_b;
        accept      = bus.in_valid && in_ready_q && !bus.flush;
    end

    mdu_iter_dp #(.XLEN(XLEN)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && !special),
        .step     (state_q == ST_CALC),
        .mode_div (is_quo_op(op_q) | is_rem_op(op_q)),
        .opa_init (dp_opa_init),
        .lo_init  (dp_lo_init),
        .hi       (dp_hi),
        .lo       (dp_lo)
    );

    // Sign fix-up and result select from the finished datapath registers
    always_comb begin
        prod = {dp_hi, dp_lo};
        if (neg_q) begin
            prod = -prod;
        end
        quo = neg_q ? -dp_lo : dp_lo;
        rem = neg_q ? -dp_hi : dp_hi;
        case (op_q)
            OP_MUL:                       fix_val = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod[2*XLEN-1:XLEN];
            OP_MULW:                      fix_val = sext32(dp_lo[63:32]);
            OP_DIV, OP_DIVU:              fix_val = quo;
            OP_REM, OP_REMU:              fix_val = rem;
            OP_DIVW, OP_DIVUW:            fix_val = sext32(quo[31:0]);
            OP_REMW, OP_REMUW:            fix_val = sext32(rem[31:0]);
            default:                      fix_val = '0;
        endcase
    end

    // Sequencer FSM with registered handshake outputs; flush kills any in-flight op
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_MUL;
            neg_q       <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (state_q != ST_IDLE && bus.flush) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q       <= bus.op;
                        neg_q      <= neg_c;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        if (special) begin
                            result_q    <= special_val;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            cnt_q   <= is_w ? MDU_CNT_W'(MDU_N32) : MDU_CNT_W'(MDU_N64);
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    cnt_q <= cnt_q - MDU_CNT_W'(1);
                    if (cnt_q == MDU_CNT_W'(1)) begin
                        state_q <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    result_q    <= fix_val;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_exe_mdu_seq.sv
// Self-checking bench for exe_mdu_seq: directed, special-case, random, backpressure, flush, reset.
module tb_exe_mdu_seq;
    import exe_mdu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    exe_mdu_seq_if #(.XLEN(64)) bus ();

    exe_mdu_seq #(.XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: RISC-V M-extension results from plain wide arithmetic
    function automatic logic [63:0] ref_result(input mdu_op_e o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pa, pb, p;
        logic [31:0]  a32, b32, t32;
        logic [63:0]  r;
        a32 = a[31:0];
        b32 = b[31:0];
        pa  = {64'h0, a};
        pb  = {64'h0, b};
        r   = '0;
        t32 = '0;
        case (o)
            OP_MUL:    begin p = pa * pb; r = p[63:0]; end
            OP_MULH:   begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; r = p[127:64]; end
            OP_MULHSU: begin pa = {{64{a[63]}}, a}; p = pa * pb; r = p[127:64]; end
            OP_MULHU:  begin p = pa * pb; r = p[127:64]; end
            OP_DIV: begin
                if (b == 0) r = '1;
                else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                else r = $signed(a) / $signed(b);
            end
            OP_REM: begin
                if (b == 0) r = a;
                else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                else r = $signed(a) % $signed(b);
            end
            OP_DIVU: r = (b == 0) ? '1 : a / b;
            OP_REMU: r = (b == 0) ? a : a % b;
            OP_MULW: begin t32 = a32 * b32; r = {{32{t32[31]}}, t32}; end
            OP_DIVW: begin
                if (b32 == 0) t32 = '1;
                else if (a32 == 32'h8000_0000 && b32 == '1) t32 = a32;
                else t32 = $signed(a32) / $signed(b32);
                r = {{32{t32[31]}}, t32};
            end
            OP_REMW: begin
                if (b32 == 0) t32 = a32;
                else if (a32 == 32'h8000_0000 && b32 == '1) t32 = '0;
                else t32 = $signed(a32) % $signed(b32);
                r = {{32{t32[31]}}, t32};
            end
            OP_DIVUW: begin t32 = (b32 == 0) ? '1 : a32 / b32; r = {{32{t32[31]}}, t32}; end
            OP_REMUW: begin t32 = (b32 == 0) ? a32 : a32 % b32; r = {{32{t32[31]}}, t32}; end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Reference latency: divide-by-zero/overflow finish next cycle, else N+2
    function automatic int ref_latency(input mdu_op_e o, input logic [63:0] a, input logic [63:0] b);
        logic sp;
        case (o)
            OP_DIV, OP_REM:   sp = (b == 0) || (a == 64'h8000_0000_0000_0000 && b == '1);
            OP_DIVU, OP_REMU: sp = (b == 0);
            OP_DIVW, OP_REMW: sp = (b[31:0] == 0) || (a[31:0] == 32'h8000_0000 && b[31:0] == '1);
            OP_DIVUW, OP_REMUW: sp = (b[31:0] == 0);
            default: sp = 1'b0;
        endcase
        if (sp) return 1;
        return (o inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW}) ? 34 : 66;
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 64'h0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_8000_0000;
            4: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Issue one op, wait (bounded) for the result, then consume it
    task automatic do_op(input mdu_op_e o, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat, output bit busy_ok);
        for (int i = 0; i < 200 && !bus.in_ready; i++) tick();
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.src1     = a;
        bus.src2     = b;
        tick();
        bus.in_valid = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 200) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        res = bus.result;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.result !== 64'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        mdu_op_e     ops [3] = '{OP_MUL, OP_MULHU, OP_MULW};
        logic [63:0] av  [3] = '{64'd7, '1, 64'h7FFF_FFFF};
        logic [63:0] bv  [3] = '{64'hFFFF_FFFF_FFFF_FFFD, '1, 64'd2};
        logic [63:0] ev  [3] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE};
        int          lv  [3] = '{66, 66, 34};
        logic [63:0] r;
        int          lat;
        bit          bok;
        for (int i = 0; i < 3; i++) begin
            do_op(ops[i], av[i], bv[i], r, lat, bok);
            checks++; if (r !== ev[i]) begin errors++; $display("FAIL mul_%s result got=%h exp=%h", ops[i].name(), r, ev[i]); end
            checks++; if (lat != lv[i]) begin errors++; $display("FAIL mul_%s latency got=%0d exp=%0d", ops[i].name(), lat, lv[i]); end
            checks++; if (!bok) begin errors++; $display("FAIL mul_%s busy got=dropped exp=held", ops[i].name()); end
        end
    endtask

    task automatic test_div();
        mdu_op_e     ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMUW};
        logic [63:0] av  [4] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'hFFFF_FFFF};
        logic [63:0] bv  [4] = '{64'd2, 64'd2, 64'd7, 64'd16};
        logic [63:0] ev  [4] = '{64'hFFFF_FFFF_FFFF_FFFD, '1, 64'd14, 64'd15};
        int          lv  [4] = '{66, 66, 66, 34};
        logic [63:0] r;
        int          lat;
        bit          bok;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], av[i], bv[i], r, lat, bok);
            checks++; if (r !== ev[i]) begin errors++; $display("FAIL div_%s result got=%h exp=%h", ops[i].name(), r, ev[i]); end
            checks++; if (lat != lv[i]) begin errors++; $display("FAIL div_%s latency got=%0d exp=%0d", ops[i].name(), lat, lv[i]); end
        end
    endtask

    task automatic test_special();
        mdu_op_e     ops [4] = '{OP_DIV, OP_REM, OP_DIV, OP_REMW};
        logic [63:0] av  [4] = '{64'h123, 64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000};
        logic [63:0] bv  [4] = '{64'h0, 64'h0, '1, '1};
        logic [63:0] ev  [4] = '{'1, 64'd5, 64'h8000_0000_0000_0000, 64'h0};
        logic [63:0] r;
        int          lat;
        bit          bok;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], av[i], bv[i], r, lat, bok);
            checks++; if (r !== ev[i]) begin errors++; $display("FAIL special_%s result got=%h exp=%h", ops[i].name(), r, ev[i]); end
            checks++; if (lat != 1) begin errors++; $display("FAIL special_%s latency got=%0d exp=1", ops[i].name(), lat); end
        end
    endtask

    task automatic test_random();
        mdu_op_e     o;
        logic [63:0] a, b, r, e;
        int          lat, el;
        bit          bok;
        for (int i = 0; i < 40; i++) begin
            o  = mdu_op_e'($urandom_range(0, 12));
            a  = pick_operand();
            b  = pick_operand();
            e  = ref_result(o, a, b);
            el = ref_latency(o, a, b);
            do_op(o, a, b, r, lat, bok);
            checks++; if (r !== e) begin errors++; $display("FAIL rand_%s a=%h b=%h got=%h exp=%h", o.name(), a, b, r, e); end
            checks++; if (lat != el) begin errors++; $display("FAIL rand_lat_%s got=%0d exp=%0d", o.name(), lat, el); end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] r0;
        int          n;
        bit          stable;
        bus.in_valid = 1'b1; bus.op = OP_MULH; bus.src1 = 64'hFFFF_FFFF_FFFF_FFFE; bus.src2 = 64'd3;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 200) begin tick(); n++; end
        r0 = bus.result;
        checks++; if (r0 !== '1) begin errors++; $display("FAIL bp_result got=%h exp=%h", r0, 64'hFFFF_FFFF_FFFF_FFFF); end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.result !== r0 || bus.in_ready !== 1'b0) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL bp_hold got=changed exp=stable valid=%b result=%h", bus.out_valid, bus.result); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL bp_release got=ready%b busy%b valid%b exp=ready1 busy0 valid0", bus.in_ready, bus.busy, bus.out_valid); end
        bus.in_valid = 1'b1; bus.op = OP_DIVU; bus.src1 = 64'd1000; bus.src2 = 64'd33;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept got=busy%b exp=busy1", bus.busy); end
        n = 0;
        while (!bus.out_valid && n < 200) begin tick(); n++; end
        checks++; if (bus.result !== 64'd30) begin errors++; $display("FAIL bp_next_result got=%h exp=%h", bus.result, 64'd30); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [63:0] r;
        int          lat;
        bit          bok, seen;
        // flush in IDLE blocks the accept
        bus.in_valid = 1'b1; bus.flush = 1'b1; bus.op = OP_MUL; bus.src1 = 64'd3; bus.src2 = 64'd4;
        tick();
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle got=busy%b exp=busy0", bus.busy); end
        // flush mid-CALC
        bus.in_valid = 1'b1; bus.op = OP_DIV; bus.src1 = 64'd999; bus.src2 = 64'd7;
        tick();
        bus.in_valid = 1'b0;
        repeat (20) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL flush_calc got=busy%b ready%b valid%b exp=busy0 ready1 valid0", bus.busy, bus.in_ready, bus.out_valid); end
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL flush_no_valid got=valid exp=none"); end
        do_op(OP_DIVU, 64'd100, 64'd7, r, lat, bok);
        checks++; if (r !== 64'd14) begin errors++; $display("FAIL flush_next_result got=%h exp=%h", r, 64'd14); end
        // flush together with out_ready in DONE
        bus.in_valid = 1'b1; bus.op = OP_DIVU; bus.src1 = 64'd9; bus.src2 = 64'd0;
        tick();
        bus.in_valid = 1'b0;
        bus.flush = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL flush_done got=valid%b ready%b exp=valid0 ready1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] r;
        int          lat;
        bit          bok;
        do_op(OP_MUL, 64'd6, 64'd7, r, lat, bok);
        checks++; if (r !== 64'd42) begin errors++; $display("FAIL rstmid_pre got=%h exp=%h", r, 64'd42); end
        bus.in_valid = 1'b1; bus.op = OP_MULHU; bus.src1 = '1; bus.src2 = 64'd5;
        tick();
        bus.in_valid = 1'b0;
        repeat (15) tick();
        rst = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 64'h0)
            begin errors++; $display("FAIL rstmid got=ready%b valid%b busy%b result=%h exp=ready1 valid0 busy0 result=0",
                                     bus.in_ready, bus.out_valid, bus.busy, bus.result); end
        rst = 1'b0;
        tick();
        do_op(OP_REMU, 64'd100, 64'd7, r, lat, bok);
        checks++; if (r !== 64'd2) begin errors++; $display("FAIL rstmid_post got=%h exp=%h", r, 64'd2); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = OP_MUL;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_random();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
